simple_steer_wr: RTL and testbench

Dataflow steer (branch) stage that sits directly downstream of simple_arbiter_wr and consumes its out_data / chose_right pair. A data token and a 1-bit select token are joined. The data token is routed to the left or right output channel. Each output channel has a 2-entry elastic buffer, so one stalled consumer never blocks tokens headed to the other channel once they are buffered.

---
 rtl/simple_steer_wr.sv | 108 ++++++++++
 tb/tb_simple_steer_wr.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/simple_steer_wr.sv
// simple_steer_wr
// Dataflow steer (branch) stage. A data token and a 1-bit select token are
// joined. The payload is pushed into the left or right 2-entry elastic buffer.
// Each buffer drains to its own consumer, so a stalled consumer only blocks
// tokens headed to its own side.
//
// Ports:
//   clk               clock, rising edge
//   reset             synchronous, active-high
//   in_data  [F:0]    data token {valid, payload}
//   in_back_stop      1 = producer must hold in_data
//   select   [1:0]    select token {valid, go_right}
//   select_back_stop  1 = producer must hold select
//   left_data  [F:0]  left channel token {valid, payload}
//   left_down_stop    1 = left consumer refuses the token
//   right_data [F:0]  right channel token {valid, payload}
//   right_down_stop   1 = right consumer refuses the token
module simple_steer_wr #(
  parameter int F     = 8,
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [F:0] in_data,
  output logic       in_back_stop,
  input  logic [1:0] select,
  output logic       select_back_stop,
  output logic [F:0] left_data,
  input  logic       left_down_stop,
  output logic [F:0] right_data,
  input  logic       right_down_stop
);

  localparam logic [1:0] FULL_CNT = 2'(DEPTH);

  // Index 0 is the left channel, index 1 the right channel.
  logic [F-1:0] mem [2][2];
  logic [1:0]   rd_ptr;
  logic [1:0]   wr_ptr;
  logic [1:0]   cnt [2];

  logic       dv;
  logic       sv;
  logic       tgt;
  logic       tgt_ready;
  logic       fire;
  logic [1:0] not_full;
  logic [1:0] has_tok;
  logic [1:0] push;
  logic [1:0] pop;
  logic [1:0] down_stop;

  assign down_stop = {right_down_stop, left_down_stop};

  always_comb begin
    dv = in_data[F];
    sv = select[1];
    tgt = select[0];
    not_full = {cnt[1] != FULL_CNT, cnt[0] != FULL_CNT};
    has_tok = {cnt[1] != 2'd0, cnt[0] != 2'd0};
    // Readiness comes from the registered counts only, so no down_stop
    // reaches the back-stops combinationally; a full buffer being drained
    // this cycle still refuses a new token (one bubble).
    tgt_ready = tgt ? not_full[1] : not_full[0];
    fire = dv & sv & tgt_ready;
    push = {fire & tgt, fire & ~tgt};
    pop = has_tok & ~down_stop;
    in_back_stop = dv & ~fire;
    select_back_stop = sv & ~fire;
    left_data = has_tok[0] ? {1'b1, mem[0][rd_ptr[0]]} : '0;
    right_data = has_tok[1] ? {1'b1, mem[1][rd_ptr[1]]} : '0;
  end

  // Storage carries no reset; stale entries are unreachable once the
  // pointers and counts are cleared.
  always_ff @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (push[s]) mem[s][wr_ptr[s]] <= in_data[F-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (push[s]) wr_ptr[s] <= ~wr_ptr[s];
        if (pop[s]) rd_ptr[s] <= ~rd_ptr[s];
        case ({push[s], pop[s]})
          2'b10:   cnt[s] <= cnt[s] + 2'd1;
          2'b01:   cnt[s] <= cnt[s] - 2'd1;
          default: cnt[s] <= cnt[s];
        endcase
      end
    end
  end

  always @(posedge clk) begin
    if (!reset) begin
      assert (!(push[0] && cnt[0] == FULL_CNT));
      assert (!(push[1] && cnt[1] == FULL_CNT));
    end
  end

endmodule

// File: tb/tb_simple_steer_wr.sv
module tb_simple_steer_wr;

  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] in_data;
  logic       in_back_stop;
  logic [1:0] select;
  logic       select_back_stop;
  logic [8:0] left_data;
  logic       left_down_stop;
  logic [8:0] right_data;
  logic       right_down_stop;

  int passed = 0;
  int total  = 0;

  simple_steer_wr #(.F(8), .DEPTH(2)) dut (
    .clk              (clk),
    .reset            (reset),
    .in_data          (in_data),
    .in_back_stop     (in_back_stop),
    .select           (select),
    .select_back_stop (select_back_stop),
    .left_data        (left_data),
    .left_down_stop   (left_down_stop),
    .right_data       (right_data),
    .right_down_stop  (right_down_stop)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst;
    logic [8:0] din;
    logic [1:0] sel;
    logic       lds;
    logic       rds;
    logic       ibs;
    logic       sbs;
    logic [8:0] l;
    logic [8:0] r;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input string name, input logic rst, input logic [8:0] din,
                     input logic [1:0] sel, input logic lds, input logic rds,
                     input logic ibs, input logic sbs,
                     input logic [8:0] l, input logic [8:0] r);
    vec_t v;
    v.name = name; v.rst = rst; v.din = din; v.sel = sel; v.lds = lds;
    v.rds = rds; v.ibs = ibs; v.sbs = sbs; v.l = l; v.r = r;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [8:0] got, input logic [8:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // One clock cycle: drive inputs after the falling edge, check the outputs
  // seen before the next rising edge.
  task automatic cyc(input vec_t v);
    @(negedge clk);
    reset = v.rst;
    in_data = v.din;
    select = v.sel;
    left_down_stop = v.lds;
    right_down_stop = v.rds;
    #1;
    chk({v.name, ".in_back_stop"}, {8'h0, in_back_stop}, {8'h0, v.ibs});
    chk({v.name, ".select_back_stop"}, {8'h0, select_back_stop}, {8'h0, v.sbs});
    chk({v.name, ".left_data"}, left_data, v.l);
    chk({v.name, ".right_data"}, right_data, v.r);
  endtask

  task automatic step(input string name, input logic rst, input logic [8:0] din,
                      input logic [1:0] sel, input logic lds, input logic rds,
                      input logic ibs, input logic sbs,
                      input logic [8:0] l, input logic [8:0] r);
    vec_t v;
    v.name = name; v.rst = rst; v.din = din; v.sel = sel; v.lds = lds;
    v.rds = rds; v.ibs = ibs; v.sbs = sbs; v.l = l; v.r = r;
    cyc(v);
  endtask

  initial begin
    reset = 1'b1;
    in_data = '0;
    select = '0;
    left_down_stop = 1'b0;
    right_down_stop = 1'b0;
    repeat (2) @(negedge clk);

    //   name        rst din     sel    lds rds ibs sbs left    right
    add("rst",        1, 9'h000, 2'b00, 0, 0, 0, 0, 9'h000, 9'h000);
    add("idle",       0, 9'h000, 2'b00, 0, 0, 0, 0, 9'h000, 9'h000);
    add("l_fire",     0, 9'h1A5, 2'b10, 0, 0, 0, 0, 9'h000, 9'h000);
    add("l_out",      0, 9'h000, 2'b00, 0, 0, 0, 0, 9'h1A5, 9'h000);
    add("l_gone",     0, 9'h000, 2'b00, 0, 0, 0, 0, 9'h000, 9'h000);
    add("nosel0",     0, 9'h1FF, 2'b00, 0, 0, 1, 0, 9'h000, 9'h000);
    add("nosel1",     0, 9'h1FF, 2'b00, 0, 0, 1, 0, 9'h000, 9'h000);
    add("nosel2",     0, 9'h1FF, 2'b00, 0, 0, 1, 0, 9'h000, 9'h000);
    add("r_fire",     0, 9'h1FF, 2'b11, 0, 0, 0, 0, 9'h000, 9'h000);
    add("r_out",      0, 9'h000, 2'b00, 0, 0, 0, 0, 9'h000, 9'h1FF);
    add("r_gone",     0, 9'h000, 2'b00, 0, 0, 0, 0, 9'h000, 9'h000);
    add("nodata",     0, 9'h0EE, 2'b11, 0, 0, 0, 1, 9'h000, 9'h000);
    add("st_101",     0, 9'h101, 2'b11, 0, 1, 0, 0, 9'h000, 9'h000);
    add("st_102",     0, 9'h102, 2'b11, 0, 1, 0, 0, 9'h000, 9'h101);
    add("st_103a",    0, 9'h103, 2'b11, 0, 1, 1, 1, 9'h000, 9'h101);
    add("st_1AA",     0, 9'h1AA, 2'b10, 0, 1, 0, 0, 9'h000, 9'h101);
    add("st_103b",    0, 9'h103, 2'b11, 0, 1, 1, 1, 9'h1AA, 9'h101);
    add("rel_bubble", 0, 9'h103, 2'b11, 0, 0, 1, 1, 9'h000, 9'h101);
    add("rel_103",    0, 9'h103, 2'b11, 0, 0, 0, 0, 9'h000, 9'h102);
    add("rel_out103", 0, 9'h000, 2'b00, 0, 0, 0, 0, 9'h000, 9'h103);
    add("rel_empty",  0, 9'h000, 2'b00, 0, 0, 0, 0, 9'h000, 9'h000);

    foreach (tbl[i]) cyc(tbl[i]);

    // Alternating sides, no stalls: every token accepted on arrival and
    // each appears one cycle later on its own side only.
    for (int i = 0; i <= 8; i++) begin
      logic [8:0] d, el, er;
      logic [1:0] s;
      d  = (i < 8) ? 9'h1C0 + 9'(i) : 9'h000;
      s  = (i < 8) ? {1'b1, i[0]} : 2'b00;
      el = 9'h000;
      er = 9'h000;
      if (i >= 1) begin
        if (((i - 1) % 2) == 0) el = 9'h1C0 + 9'(i - 1);
        else                    er = 9'h1C0 + 9'(i - 1);
      end
      step($sformatf("alt%0d", i), 0, d, s, 0, 0, 0, 0, el, er);
    end

    // Left buffer ordering across pointer wrap, then reset with it full.
    step("f_111",   0, 9'h111, 2'b10, 1, 0, 0, 0, 9'h000, 9'h000);
    step("f_122",   0, 9'h122, 2'b10, 1, 0, 0, 0, 9'h111, 9'h000);
    step("f_pop",   0, 9'h000, 2'b00, 0, 0, 0, 0, 9'h111, 9'h000);
    step("f_133",   0, 9'h133, 2'b10, 1, 0, 0, 0, 9'h122, 9'h000);
    step("f_full",  0, 9'h144, 2'b10, 1, 0, 1, 1, 9'h122, 9'h000);
    step("f_rst",   1, 9'h000, 2'b00, 1, 0, 0, 0, 9'h122, 9'h000);
    step("post_rst",0, 9'h000, 2'b00, 0, 0, 0, 0, 9'h000, 9'h000);
    step("p_155",   0, 9'h155, 2'b10, 0, 0, 0, 0, 9'h000, 9'h000);
    step("p_out",   0, 9'h000, 2'b00, 0, 0, 0, 0, 9'h155, 9'h000);
    step("p_empty", 0, 9'h000, 2'b00, 0, 0, 0, 0, 9'h000, 9'h000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
